// File: rtl/instruction_compressor.sv
// Purpose: replaces adjacent instruction pairs found in a small dictionary with a single token word.
// Latency: 1 cycle from the accepting edge to out_valid; the first word of a stream is held until its successor arrives.
// Backpressure: in_ready drops while the output register is full and out_ready is low, and during the FLUSH cycle.
module instruction_compressor #(
  parameter int                      WIDTH        = 32,
  parameter int                      encodeLength = 4,
  parameter logic [encodeLength-1:0] OPcode       = 4'b1111,
  parameter int                      ENTRIES      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_instr,
  input  logic                       in_last,
  input  logic                       wme,
  input  logic [$clog2(ENTRIES)-1:0] wa,
  input  logic [WIDTH-1:0]           wd0,
  input  logic [WIDTH-1:0]           wd1,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_word,
  output logic                       out_is_token,
  output logic                       err_escape,
  output logic [15:0]                tok_cnt,
  output logic [15:0]                raw_cnt
);

  localparam int AW  = $clog2(ENTRIES);
  localparam int LOW = WIDTH - encodeLength;

  typedef enum logic [1:0] {EMPTY, HELD, FLUSH} state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   hold, hold_d;
  logic [WIDTH-1:0]   pair_first  [ENTRIES];
  logic [WIDTH-1:0]   pair_second [ENTRIES];
  logic [ENTRIES-1:0] entry_valid;

  logic               out_free, accept;
  logic               match_hit;
  logic [AW-1:0]      match_idx;
  logic [WIDTH-1:0]   token;
  logic               load, load_tok;
  logic [WIDTH-1:0]   load_word;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state != FLUSH) && out_free;
  assign accept   = in_valid && in_ready;

  // Token carries the byte address of the pair (8 bytes per entry) under the marker.
  assign token = {OPcode, {(LOW-AW-3){1'b0}}, match_idx, 3'b000};

  // Dictionary valid bits: the only dictionary state cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) entry_valid <= '0;
    else if (wme) entry_valid[wa] <= 1'b1;
  end

  // Dictionary pair storage; lookups this cycle still see the old contents.
  always_ff @(posedge clk) begin
    if (wme) begin
      pair_first[wa]  <= wd0;
      pair_second[wa] <= wd1;
    end
  end

  // Priority search from the top down so the lowest matching index wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entry_valid[i] && pair_first[i] == hold && pair_second[i] == in_instr) begin
        match_hit = 1'b1;
        match_idx = i[AW-1:0];
      end
    end
  end

  // State and hold register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      hold  <= '0;
    end else begin
      state <= state_d;
      hold  <= hold_d;
    end
  end

  // Next-state logic and selection of what, if anything, loads the output register.
  always_comb begin
    state_d   = state;
    hold_d    = hold;
    load      = 1'b0;
    load_tok  = 1'b0;
    load_word = '0;
    case (state)
      EMPTY: begin
        if (accept) begin
          if (in_last) begin
            load      = 1'b1;
            load_word = in_instr;
          end else begin
            hold_d  = in_instr;
            state_d = HELD;
          end
        end
      end
      HELD: begin
        if (accept) begin
          load = 1'b1;
          if (match_hit) begin
            load_tok  = 1'b1;
            load_word = token;
            state_d   = EMPTY;
          end else begin
            load_word = hold;
            hold_d    = in_instr;
            state_d   = in_last ? FLUSH : HELD;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          load      = 1'b1;
          load_word = hold;
          state_d   = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output register, escape flag and emission counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_word     <= '0;
      out_is_token <= 1'b0;
      err_escape   <= 1'b0;
      tok_cnt      <= '0;
      raw_cnt      <= '0;
    end else if (load) begin
      out_valid    <= 1'b1;
      out_word     <= load_word;
      out_is_token <= load_tok;
      if (load_tok) begin
        tok_cnt <= tok_cnt + 16'd1;
      end else begin
        raw_cnt <= raw_cnt + 16'd1;
        if (load_word[WIDTH-1 -: encodeLength] == OPcode) err_escape <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
